alu_exec: RTL and testbench
===========================

// Module: alu_exec
// PURPOSE
//  RV32I execute stage; sits directly downstream of the ALU decoder.
//  Latches op1/op2/alu_sel and computes the result through a valid/ready handshake.
//  Non-shift ops complete in one cycle. SLL/SRL/SRA use an iterative shifter
//  that moves SHIFT_STEP bits per cycle, which keeps area small.
// PARAMETERS
//  XLEN        32  datapath width
//  SHIFT_STEP  1   max bits shifted per cycle; power of 2, 1..16
// PORTS
//  clk        in   1     clock, rising edge
//  rst_n      in   1     asynchronous reset, active-low
//  flush      in   1     synchronous abort; drops the op in flight
//  in_valid   in   1     op1/op2/alu_sel valid
//  in_ready   out  1     stage can accept an op this cycle
//  op1        in   XLEN  operand 1 (rs1, or LUI imm20 in [19:0])
//  op2        in   XLEN  operand 2 (rs2, -rs2 for SUB, imm, or shamt)
//  alu_sel    in   5     function select, encoding below
//  out_valid  out  1     result valid
//  out_ready  in   1     consumer takes result
//  result     out  XLEN  ALU result
//  illegal    out  1     alu_sel was not a defined code; qualified by out_valid
// BEHAVIOUR
//  alu_sel encoding:
//   0 ADD    1 SLL    2 SLT    3 SLTU   4 XOR
//   5 SRL    6 SRA    7 OR     8 AND    9 LUI
//   10..31 illegal: result=0, illegal=1
//  - ADD: op1+op2, mod 2^XLEN. SUB arrives already negated; no carry/overflow output.
//  - SLT signed, SLTU unsigned: result = {31'b0, lt}.
//  - LUI: result = op1 << 12.
//  - Shifts: amount = op2[4:0]; upper op2 bits are ignored.
//  - SRA fills with the sign bit of op1.
//  FSM states: IDLE, SHIFT, DONE.
//  - in_ready = (state==IDLE) | (state==DONE & out_ready).
//  - Accept = in_valid & in_ready. All operands and alu_sel are captured on accept.
//  - Accept, non-shift op or amount==0 -> DONE next cycle (latency 1).
//  - Accept, shift with amount>0 -> SHIFT; cnt=amount.
//  - SHIFT: each cycle shifts by s=min(cnt,SHIFT_STEP), cnt-=s; cnt reaching 0 -> DONE.
//    Latency = 1 + ceil(amount/SHIFT_STEP) cycles.
//  - DONE: out_valid=1. result and illegal stay stable until out_ready.
//    - out_ready & in_valid -> new op accepted in the same cycle (back-to-back).
//    - out_ready & !in_valid -> IDLE.
//  - out_valid is high only in DONE. result and illegal are registered outputs.
//  - flush: next state IDLE, out_valid=0, and the same-cycle accept is suppressed.
//    flush has priority over all other transitions.
//  - Reset (async, any state incl. mid-shift): state=IDLE, cnt=0, result=0,
//    illegal=0, out_valid=0, in_ready=1 once rst_n releases.
//  - Inputs are ignored while in_ready=0. The upstream stage holds them until accepted.
// TESTING
//  1. ADD op1=0x7FFFFFFF op2=1 sel=0 -> next cycle out_valid=1, result=0x80000000.
//  2. SUB via op2=-5 (0xFFFFFFFB), op1=3, sel=0 -> result=0xFFFFFFFE.
//     SLT op1=-1 op2=1 -> 1; SLTU same operands -> 0.
//  3. SRA op1=0x80000000 op2=31 (SHIFT_STEP=1) -> out_valid after 32 cycles,
//     result=0xFFFFFFFF. in_ready=0 throughout SHIFT.
//  4. SLL op2=0x20 (amount 0) -> latency 1, result=op1.
//     SHIFT_STEP=4 with SLL amount 7 -> latency 3.
//  5. Hold out_ready=0 for 5 cycles -> result stable, in_ready=0.
//     Then out_ready=1 with a new in_valid -> new op accepted that cycle; next result 1 cycle later.
//  6. Assert rst_n=0 mid-SRL (cnt=10) -> outputs 0 immediately, IDLE after release.
//     flush in DONE -> out_valid=0 next cycle. sel=12 -> result=0, illegal=1.

Source files
------------

// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - RV32I execute stage with handshake and iterative shifter
module alu_exec #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [4:0]      alu_sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  localparam logic [4:0] SEL_ADD  = 5'd0;
  localparam logic [4:0] SEL_SLL  = 5'd1;
  localparam logic [4:0] SEL_SLT  = 5'd2;
  localparam logic [4:0] SEL_SLTU = 5'd3;
  localparam logic [4:0] SEL_XOR  = 5'd4;
  localparam logic [4:0] SEL_SRL  = 5'd5;
  localparam logic [4:0] SEL_SRA  = 5'd6;
  localparam logic [4:0] SEL_OR   = 5'd7;
  localparam logic [4:0] SEL_AND  = 5'd8;
  localparam logic [4:0] SEL_LUI  = 5'd9;

  localparam logic [4:0] STEP = 5'(SHIFT_STEP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          state_q;
  logic [4:0]      cnt_q;
  logic [4:0]      sel_q;
  logic [XLEN-1:0] result_q;
  logic            illegal_q;
  logic            out_valid_q;

  logic [XLEN-1:0] acc_result_d;
  logic            acc_illegal_d;
  logic            acc_shift_d;
  logic [4:0]      amt;
  logic            accept;
  logic [4:0]      step_amt;
  logic [XLEN-1:0] shifted;

  assign amt      = op2[4:0];
  assign in_ready = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
  assign accept   = in_valid & in_ready & ~flush;

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign illegal   = illegal_q;

  // Decode the incoming op; shifts with a non-zero amount only seed the accumulator
  always_comb begin
    acc_result_d  = '0;
    acc_illegal_d = 1'b0;
    acc_shift_d   = 1'b0;
    case (alu_sel)
      SEL_ADD:  acc_result_d = op1 + op2;
      SEL_SLT:  acc_result_d = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
      SEL_SLTU: acc_result_d = {{(XLEN-1){1'b0}}, (op1 < op2)};
      SEL_XOR:  acc_result_d = op1 ^ op2;
      SEL_OR:   acc_result_d = op1 | op2;
      SEL_AND:  acc_result_d = op1 & op2;
      SEL_LUI:  acc_result_d = op1 << 12;
      SEL_SLL, SEL_SRL, SEL_SRA: begin
        acc_result_d = op1;
        acc_shift_d  = (amt != 5'd0);
      end
      default:  acc_illegal_d = 1'b1;
    endcase
  end

  // One shifter step: at most SHIFT_STEP bits, never more than what remains
  always_comb begin
    shifted  = '0;
    step_amt = (cnt_q < STEP) ? cnt_q : STEP;
    case (sel_q)
      SEL_SLL: shifted = result_q << step_amt;
      SEL_SRL: shifted = result_q >> step_amt;
      default: shifted = $signed(result_q) >>> step_amt;
    endcase
  end

  // Control FSM with registered result/illegal/out_valid; result_q doubles as the shift accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sel_q       <= '0;
      result_q    <= '0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_SHIFT: begin
          result_q <= shifted;
          cnt_q    <= cnt_q - step_amt;
          if (cnt_q == step_amt) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready && !in_valid) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
      if (accept) begin
        sel_q     <= alu_sel;
        result_q  <= acc_result_d;
        illegal_q <= acc_illegal_d;
        if (acc_shift_d) begin
          state_q     <= S_SHIFT;
          cnt_q       <= amt;
          out_valid_q <= 1'b0;
        end else begin
          state_q     <= S_DONE;
          cnt_q       <= '0;
          out_valid_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// tb/tb_alu_exec.sv - directed self-checking bench for alu_exec
module tb_alu_exec;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [4:0]  alu_sel;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        illegal;

  logic        in_valid4;
  logic        in_ready4;
  logic        out_valid4;
  logic        out_ready4;
  logic [31:0] result4;
  logic        illegal4;

  int checks;
  int errors;

  alu_exec #(.XLEN(32), .SHIFT_STEP(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .op1(op1), .op2(op2), .alu_sel(alu_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .illegal(illegal)
  );

  alu_exec #(.XLEN(32), .SHIFT_STEP(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .op1(op1), .op2(op2), .alu_sel(alu_sel),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .result(result4), .illegal(illegal4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [4:0] sel, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input logic exp_ill, input int exp_lat);
    int  n;
    logic saw_ready;
    alu_sel   = sel;
    op1       = a;
    op2       = b;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    n         = 1;
    saw_ready = 1'b0;
    while (!out_valid && n < 100) begin
      if (in_ready) saw_ready = 1'b1;
      tick();
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    check({tag, "_res"}, result, exp_res);
    check({tag, "_ill"}, {31'b0, illegal}, {31'b0, exp_ill});
    if (exp_lat > 1) check({tag, "_busy"}, {31'b0, saw_ready}, 32'd0);
    tick();
  endtask

  task automatic run_op4(input string tag, input logic [4:0] sel, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int n;
    alu_sel   = sel;
    op1       = a;
    op2       = b;
    in_valid4 = 1'b1;
    tick();
    in_valid4 = 1'b0;
    n         = 1;
    while (!out_valid4 && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    check({tag, "_res"}, result4, exp_res);
    tick();
  endtask

  initial begin
    logic bad;
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    flush      = 1'b0;
    in_valid   = 1'b0;
    in_valid4  = 1'b0;
    out_ready  = 1'b1;
    out_ready4 = 1'b1;
    op1        = '0;
    op2        = '0;
    alu_sel    = '0;

    repeat (2) tick();
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_illegal", {31'b0, illegal}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    tick();

    run_op("add_ovf", 5'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1);
    run_op("sub",     5'd0, 32'h0000_0003, 32'hFFFF_FFFB, 32'hFFFF_FFFE, 1'b0, 1);
    run_op("slt",     5'd2, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1);
    run_op("sltu",    5'd3, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1);
    run_op("xor",     5'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1);
    run_op("or",      5'd7, 32'h1200_0034, 32'h0000_5600, 32'h1200_5634, 1'b0, 1);
    run_op("and",     5'd8, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0, 1);
    run_op("lui",     5'd9, 32'h000A_BCDE, 32'h0000_0000, 32'hABCD_E000, 1'b0, 1);
    run_op("sll_amt0",5'd1, 32'h1234_5678, 32'h0000_0020, 32'h1234_5678, 1'b0, 1);
    run_op("srl_mask",5'd5, 32'h0000_00F0, 32'h0000_0024, 32'h0000_000F, 1'b0, 5);
    run_op("sll_3",   5'd1, 32'h0000_0001, 32'h0000_0003, 32'h0000_0008, 1'b0, 4);
    run_op("sra_31",  5'd6, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 1'b0, 32);
    run_op("sra_pos", 5'd6, 32'h4000_0000, 32'h0000_0002, 32'h1000_0000, 1'b0, 3);
    run_op("ill_12",  5'd12, 32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 1'b1, 1);
    run_op("ill_31",  5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1);
    run_op("legal_after_ill", 5'd0, 32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 1'b0, 1);

    run_op4("s4_sll7",  5'd1, 32'h0000_0001, 32'h0000_0007, 32'h0000_0080, 3);
    run_op4("s4_sra31", 5'd6, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 9);

    // Backpressure: result held while out_ready is low, then back-to-back accept
    alu_sel  = 5'd4;
    op1      = 32'hAAAA_0000;
    op2      = 32'h0000_AAAA;
    in_valid = 1'b1;
    tick();
    check("hold_first_valid", {31'b0, out_valid}, 32'd1);
    out_ready = 1'b0;
    alu_sel   = 5'd0;
    op1       = 32'h0000_0001;
    op2       = 32'h0000_0002;
    bad       = 1'b0;
    repeat (5) begin
      tick();
      if (result !== 32'hAAAA_AAAA || out_valid !== 1'b1 || in_ready !== 1'b0) bad = 1'b1;
    end
    check("hold_stable", {31'b0, bad}, 32'd0);
    out_ready = 1'b1;
    #1;
    check("b2b_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("b2b_valid", {31'b0, out_valid}, 32'd1);
    check("b2b_result", result, 32'h0000_0003);
    tick();
    check("b2b_drain", {31'b0, out_valid}, 32'd0);

    // Flush in DONE drops the result and suppresses the same-cycle accept
    alu_sel  = 5'd0;
    op1      = 32'd10;
    op2      = 32'd20;
    in_valid = 1'b1;
    tick();
    check("flush_pre_result", result, 32'd30);
    flush     = 1'b1;
    out_ready = 1'b0;
    op1       = 32'd1;
    op2       = 32'd1;
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("flush_valid", {31'b0, out_valid}, 32'd0);
    check("flush_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    check("flush_no_accept", {31'b0, out_valid}, 32'd0);

    // Async reset in the middle of a 20-bit SRL (cnt=10)
    alu_sel  = 5'd5;
    op1      = 32'hFFFF_FFFF;
    op2      = 32'd20;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    check("midshift_busy", {31'b0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("midrst_result", result, 32'd0);
    check("midrst_valid", {31'b0, out_valid}, 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    check("midrst_no_result", {31'b0, out_valid}, 32'd0);
    run_op("post_rst_add", 5'd0, 32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 1'b0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
